prime_gen: RTL

PRIME_GEN -- requirements
Module: prime_gen

---
 rtl/prime_gen.sv | 121 ++++++++++++
 1 files changed

// File: rtl/prime_gen.sv
// Emits every prime in 2..limit in ascending order, testing each candidate by repeated-subtraction trial division.
// Latency per candidate is data dependent; prime/prime_valid hold while out_ready is low.
module prime_gen #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] limit,
    input  logic         out_ready,
    output logic [W-1:0] prime,
    output logic         prime_valid,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] count
);

    typedef enum logic [2:0] {IDLE, LOAD, TEST, MOD, EMIT, FIN} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   cand_q, cand_d;
    logic [W-1:0]   d_q, d_d;
    logic [W-1:0]   r_q, r_d;
    logic [W-1:0]   lim_q, lim_d;
    logic [W-1:0]   cnt_q, cnt_d;
    logic [2*W-1:0] d_sq;
    logic [W-1:0]   r_sub;

    // Full-width square so large divisors never alias small candidates.
    assign d_sq  = {{W{1'b0}}, d_q} * {{W{1'b0}}, d_q};
    assign r_sub = r_q - d_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cand_q  <= '0;
            d_q     <= '0;
            r_q     <= '0;
            lim_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            d_q     <= d_d;
            r_q     <= r_d;
            lim_q   <= lim_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        d_d     = d_q;
        r_d     = r_q;
        lim_d   = lim_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    lim_d   = limit;
                    cnt_d   = '0;
                    cand_d  = W'(2);
                    d_d     = W'(2);
                    state_d = (limit < W'(2)) ? FIN : TEST;
                end
            end
            TEST: begin
                if (d_sq > {{W{1'b0}}, cand_q}) begin
                    state_d = EMIT;
                end else begin
                    r_d     = cand_q;
                    state_d = MOD;
                end
            end
            MOD: begin
                // Entry guarantees r >= d, so one subtraction is always legal here.
                r_d = r_sub;
                if (r_sub == '0) begin
                    state_d = LOAD;
                end else if (r_sub < d_q) begin
                    d_d     = d_q + 1'b1;
                    state_d = TEST;
                end
            end
            LOAD: begin
                if (cand_q == lim_q) begin
                    state_d = FIN;
                end else begin
                    cand_d  = cand_q + 1'b1;
                    d_d     = W'(2);
                    state_d = TEST;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = LOAD;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        prime       = '0;
        prime_valid = 1'b0;
        done        = 1'b0;
        busy        = (state_q != IDLE);
        count       = cnt_q;
        if (state_q == EMIT) begin
            prime       = cand_q;
            prime_valid = 1'b1;
        end
        if (state_q == FIN) begin
            done = 1'b1;
        end
    end

endmodule
